// File: rtl/caravel_wb_pkg.sv
// Shared definitions for the Caravel Wishbone responder: FSM encoding and bus widths.
package caravel_wb_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned SelWidth  = 4;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAccess  = 2'd1,
        StRespond = 2'd2
    } state_e;

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts consecutive cycles with count_en_i high; hit_o flags the Limit-th such cycle.
// Only instantiated when WB_RESPONDER_TIMEOUT_EN is defined.
module wb_timeout_counter #(
    parameter int unsigned Limit = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic count_en_i,
    output logic hit_o
);

    localparam logic [15:0] LastCount = 16'(Limit - 1);

    logic [15:0] count_q, count_d;

    // Count while enabled, otherwise hold at zero so every entry starts fresh
    always_comb begin
        count_d = '0;
        if (count_en_i) begin
            count_d = count_q + 16'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds completed cycles, so this is high during the Limit-th enabled cycle
    assign hit_o = count_en_i && (count_q == LastCount);

endmodule

// File: rtl/caravel_wb_responder.sv
// Wishbone slave bridging one outstanding request to a local peripheral handshake.
// Optional access timeout enabled with macro WB_RESPONDER_TIMEOUT_EN.
module caravel_wb_responder
    import caravel_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_WIDTH     = 28
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [SelWidth-1:0]   wb_sel_i,
    input  logic [DataWidth-1:0]  wb_data_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    output logic                  wb_ack_o,
    output logic                  wb_stall_o,
    output logic                  wb_error_o,
    output logic [DataWidth-1:0]  wb_data_o,
    output logic                  per_req_o,
    output logic                  per_we_o,
    output logic [SelWidth-1:0]   per_sel_o,
    output logic [ADDR_WIDTH-1:0] per_adr_o,
    output logic [DataWidth-1:0]  per_wdata_o,
    input  logic [DataWidth-1:0]  per_rdata_i,
    input  logic                  per_ready_i
);

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [SelWidth-1:0]   sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DataWidth-1:0]  wdata_q, wdata_d;
    logic [DataWidth-1:0]  rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  in_access;
    logic                  timeout_hit;

    assign in_access = (state_q == StAccess);

`ifdef WB_RESPONDER_TIMEOUT_EN
    wb_timeout_counter #(
        .Limit (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i      (wb_clk_i),
        .rst_i      (wb_rst_i),
        .count_en_i (in_access),
        .hit_o      (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and latch control for the accept / access / respond sequence
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (wb_cyc_i && wb_stb_i) begin
                    we_d    = wb_we_i;
                    sel_d   = wb_sel_i;
                    adr_d   = wb_adr_i;
                    wdata_d = wb_data_i;
                    rdata_d = '0;
                    // No byte lanes selected: nothing to access, answer with an error
                    if (wb_sel_i == '0) begin
                        err_d   = 1'b1;
                        state_d = StRespond;
                    end else begin
                        err_d   = 1'b0;
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                // Master abandoning the cycle beats a simultaneous peripheral completion
                if (!wb_cyc_i) begin
                    state_d = StIdle;
                end else if (per_ready_i) begin
                    if (!we_q) begin
                        rdata_d = per_rdata_i;
                    end
                    err_d   = 1'b0;
                    state_d = StRespond;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StRespond;
                end
            end
            StRespond: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and latched request fields, cleared asynchronously by reset
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode from registered state only, so reset clears them without a clock
    always_comb begin
        wb_ack_o    = (state_q == StRespond) && !err_q;
        wb_error_o  = (state_q == StRespond) && err_q;
        wb_stall_o  = (state_q != StIdle);
        wb_data_o   = wb_ack_o ? rdata_q : '0;
        per_req_o   = in_access;
        per_we_o    = we_q;
        per_sel_o   = sel_q;
        per_adr_o   = adr_q;
        per_wdata_o = wdata_q;
    end

endmodule

// File: tb/tb_caravel_wb_responder.sv
// Self-checking bench for caravel_wb_responder: directed table, reset corner cases and
// randomized transactions predicted by a transaction-level model.
module tb_caravel_wb_responder;

    localparam int unsigned AW = 28;
    localparam int unsigned T  = 8;
`ifdef WB_RESPONDER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int KAck   = 0;
    localparam int KErr   = 1;
    localparam int KAbort = 2;

    typedef struct {
        logic          we;
        logic [3:0]    sel;
        logic [AW-1:0] adr;
        logic [31:0]   wdata;
        logic [31:0]   rdata;
        int unsigned   delay;     // ready rises in ACCESS cycle delay+1
        int unsigned   abort_at;  // ACCESS cycle in which cyc drops, 0 = never
        int            exp_kind;
        logic [31:0]   exp_data;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cyc, stb, we;
    logic [3:0]    sel;
    logic [31:0]   wdata;
    logic [AW-1:0] adr;
    logic          ack, stall, err;
    logic [31:0]   rdata_o;
    logic          per_req, per_we;
    logic [3:0]    per_sel;
    logic [AW-1:0] per_adr;
    logic [31:0]   per_wdata;
    logic [31:0]   per_rdata;
    logic          per_ready;

    int total = 0;
    int bad   = 0;

    caravel_wb_responder #(
        .TIMEOUT_CYCLES (T),
        .ADDR_WIDTH     (AW)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wb_cyc_i    (cyc),
        .wb_stb_i    (stb),
        .wb_we_i     (we),
        .wb_sel_i    (sel),
        .wb_data_i   (wdata),
        .wb_adr_i    (adr),
        .wb_ack_o    (ack),
        .wb_stall_o  (stall),
        .wb_error_o  (err),
        .wb_data_o   (rdata_o),
        .per_req_o   (per_req),
        .per_we_o    (per_we),
        .per_sel_o   (per_sel),
        .per_adr_o   (per_adr),
        .per_wdata_o (per_wdata),
        .per_rdata_i (per_rdata),
        .per_ready_i (per_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outcome of a transaction from its description alone
    function automatic txn_t predict(input txn_t t);
        txn_t r;
        int unsigned ready_cyc, end_cyc;
        r         = t;
        ready_cyc = t.delay + 1;
        end_cyc   = (TO_EN && ready_cyc > T) ? T : ready_cyc;
        if (t.sel == 4'd0) begin
            r.exp_kind = KErr;
            r.exp_data = 32'd0;
        end else if (t.abort_at != 0 && t.abort_at <= end_cyc) begin
            r.exp_kind = KAbort;
            r.exp_data = 32'd0;
        end else if (ready_cyc == end_cyc) begin
            r.exp_kind = KAck;
            r.exp_data = t.we ? 32'd0 : t.rdata;
        end else begin
            r.exp_kind = KErr;
            r.exp_data = 32'd0;
        end
        return r;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_ack"},   32'(ack),   32'd0);
        chk({tag, "_err"},   32'(err),   32'd0);
        chk({tag, "_req"},   32'(per_req), 32'd0);
    endtask

    // Drive one transaction from an idle cycle and check every cycle against t.exp_*
    task automatic run_txn(input txn_t t);
        int unsigned last;
        cyc       = 1'b1;
        stb       = 1'b1;
        we        = t.we;
        sel       = t.sel;
        adr       = t.adr;
        wdata     = t.wdata;
        per_ready = 1'b0;
        chk("accept_stall", 32'(stall), 32'd0);
        step();
        stb = 1'($urandom_range(0, 1));
        if (t.sel != 4'd0) begin
            last = (t.exp_kind == KAbort) ? t.abort_at :
                   (t.exp_kind == KAck)   ? t.delay + 1 : T;
            for (int unsigned i = 1; i <= last; i++) begin
                chk("acc_req",   32'(per_req),   32'd1);
                chk("acc_stall", 32'(stall),     32'd1);
                chk("acc_resp",  {30'd0, ack, err}, 32'd0);
                chk("acc_we",    32'(per_we),    32'(t.we));
                chk("acc_sel",   32'(per_sel),   32'(t.sel));
                chk("acc_adr",   32'(per_adr),   32'(t.adr));
                chk("acc_wdata", per_wdata,      t.wdata);
                per_ready = (i == t.delay + 1);
                per_rdata = per_ready ? t.rdata : $urandom;
                cyc       = !(t.abort_at == i);
                stb       = 1'($urandom_range(0, 1));
                step();
            end
        end
        per_ready = 1'b0;
        if (t.exp_kind == KAbort) begin
            cyc = 1'b0;
            stb = 1'b0;
            check_idle("abort");
        end else begin
            cyc = 1'($urandom_range(0, 1));
            stb = 1'($urandom_range(0, 1));
            chk("resp_ack",   32'(ack),     32'(t.exp_kind == KAck));
            chk("resp_err",   32'(err),     32'(t.exp_kind == KErr));
            chk("resp_data",  rdata_o,      t.exp_data);
            chk("resp_stall", 32'(stall),   32'd1);
            chk("resp_req",   32'(per_req), 32'd0);
            step();
            cyc = 1'b0;
            stb = 1'b0;
            check_idle("post");
            chk("post_data", rdata_o, 32'd0);
        end
    endtask

    txn_t vec[8];
    txn_t t;

    initial begin
        rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; wdata = 0; adr = 0;
        per_rdata = 0; per_ready = 0;
        #2;
        check_idle("rst");
        chk("rst_data", rdata_o, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        //          we  sel    adr          wdata         rdata         dly ab  kind    data
        vec[0] = '{1'b0, 4'hF, 28'h0000010, 32'h0,        32'hDEADBEEF, 0,  0,  KAck,   32'hDEADBEEF};
        vec[1] = '{1'b1, 4'hF, 28'h0000004, 32'h12345678, 32'hCAFEF00D, 3,  0,  KAck,   32'h0};
        vec[2] = '{1'b1, 4'h0, 28'h0000008, 32'h55AA55AA, 32'h0,        0,  0,  KErr,   32'h0};
        vec[3] = '{1'b0, 4'hF, 28'h0000020, 32'h0,        32'h11111111, 6,  3,  KAbort, 32'h0};
        vec[4] = '{1'b0, 4'h3, 28'h0000024, 32'h0,        32'h22222222, 1,  2,  KAbort, 32'h0};
        vec[5] = '{1'b0, 4'h3, 28'hABCDEF0, 32'h0,        32'hA5A5A5A5, 5,  0,  KAck,   32'hA5A5A5A5};
        vec[6] = '{1'b0, 4'hC, 28'h0000030, 32'h0,        32'h33333333, 7,  0,  KAck,   32'h33333333};
        if (TO_EN)
            vec[7] = '{1'b0, 4'h1, 28'h0000040, 32'h0, 32'h44444444, 20, 0, KErr, 32'h0};
        else
            vec[7] = '{1'b0, 4'h1, 28'h0000040, 32'h0, 32'h44444444, 20, 0, KAck, 32'h44444444};
        for (int i = 0; i < 8; i++) begin
            run_txn(vec[i]);
        end

        // After an abort the very next request must go through normally
        run_txn(vec[0]);

        // Asynchronous reset two cycles into ACCESS
        cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = 28'h0000050; wdata = 32'h0BADF00D;
        step();
        stb = 0;
        step();
        step();
        chk("pre_rst_req", 32'(per_req), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        chk("async_rst_we",    32'(per_we),  32'd0);
        chk("async_rst_sel",   32'(per_sel), 32'd0);
        chk("async_rst_adr",   32'(per_adr), 32'd0);
        chk("async_rst_wdata", per_wdata,    32'd0);
        chk("async_rst_data",  rdata_o,      32'd0);
        cyc = 0;
        @(posedge clk);
        #2;
        check_idle("held_rst");
        rst = 1'b0;
        // First edge after reset release must accept
        run_txn(vec[5]);

        // Randomized transactions with idle gaps
        for (int n = 0; n < 60; n++) begin
            t.we       = 1'($urandom_range(0, 1));
            t.sel      = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            t.adr      = AW'($urandom);
            t.wdata    = $urandom;
            t.rdata    = $urandom;
            t.delay    = $urandom_range(0, 11);
            t.abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 13) : 0;
            t.exp_kind = KAck;
            t.exp_data = 32'd0;
            t = predict(t);
            run_txn(t);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                cyc = 1'($urandom_range(0, 1));
                stb = 1'b0;
                step();
                check_idle("gap");
                cyc = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard ceiling so a wedged run still reports
    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
